// File: rtl/bird_datapath_if.sv
// Plot/handshake bundle between the bird control FSM (master) and its datapath (slave).
// The FSM drives the state code; the datapath returns the plot stream and status flags.
interface bird_datapath_if;
  logic [3:0] state;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done_drawing;
  logic       flying;

  modport master (
    output state,
    input  x, y, colour, plot, done_drawing, flying
  );

  modport slave (
    input  state,
    output x, y, colour, plot, done_drawing, flying
  );
endinterface

// File: rtl/bird_datapath.sv
// Bird datapath: owns position and animation mode, and sweeps the sprite rectangle
// onto the plot interface for CLEAR and DRAW states commanded by the bird FSM.
module bird_datapath #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         SPRITE_W    = 8,
  parameter int         SPRITE_H    = 8,
  parameter int         STEP        = 4,
  parameter int         FALL_STEP   = 4,
  parameter int         START_X     = 76,
  parameter int         START_Y     = 104,
  parameter logic [2:0] BG_COLOUR   = 3'b011,
  parameter logic [2:0] BIRD_COLOUR = 3'b000,
  parameter logic [2:0] HIT_COLOUR  = 3'b100
) (
  input logic             clk,
  input logic             reset,
  bird_datapath_if.slave  bus
);

  localparam int N     = SPRITE_W * SPRITE_H;
  localparam int CW    = $clog2(N + 1);
  localparam int MAX_X = SCREEN_W - SPRITE_W;
  localparam int MAX_Y = SCREEN_H - SPRITE_H;

  typedef enum logic [3:0] {
    ST_HOLD       = 4'b0000,
    ST_CLEAR      = 4'b0001,
    ST_UP_LEFT    = 4'b0010,
    ST_UP_RIGHT   = 4'b0011,
    ST_PREHOLD    = 4'b0100,
    ST_DRAW       = 4'b0101,
    ST_DOWN_RIGHT = 4'b0110,
    ST_DOWN_LEFT  = 4'b0111,
    ST_SHOT       = 4'b1000,
    ST_ESCAPE     = 4'b1001,
    ST_RESET      = 4'b1010
  } state_e;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_FALL   = 2'd1,
    MODE_ESCAPE = 2'd2
  } mode_e;

  logic [7:0]    pos_x_q, pos_x_d;
  logic [6:0]    pos_y_q, pos_y_d;
  mode_e         mode_q, mode_d;
  logic          flying_q, flying_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        prev_q, prev_d;

  state_e        st;
  logic          sweep;
  logic [CW-1:0] cnt_eff;

  // Undefined codes collapse to HOLD so they can never start a sweep or move the bird.
  always_comb begin
    st = state_e'(bus.state);
    if (bus.state > 4'b1010) st = ST_HOLD;
  end

  assign sweep   = (st == ST_CLEAR) || (st == ST_DRAW);
  // A state change restarts the sweep in the same cycle, so pixel 0 lands on in-state cycle 0.
  assign cnt_eff = (st != prev_q) ? '0 : cnt_q;

  always_comb begin
    int ci;
    ci = int'(cnt_eff);
    bus.plot         = sweep && (ci < N);
    bus.done_drawing = sweep && (ci == N);
    bus.flying       = flying_q;
    bus.x            = pos_x_q;
    bus.y            = pos_y_q;
    if (sweep) begin
      bus.x = 8'(int'(pos_x_q) + ci % SPRITE_W);
      bus.y = 7'(int'(pos_y_q) + ci / SPRITE_W);
    end
    if (st == ST_CLEAR)          bus.colour = BG_COLOUR;
    else if (mode_q == MODE_FALL) bus.colour = HIT_COLOUR;
    else                          bus.colour = BIRD_COLOUR;
  end

  always_comb begin
    int px;
    int py;
    px       = int'(pos_x_q);
    py       = int'(pos_y_q);
    mode_d   = mode_q;
    flying_d = flying_q;
    prev_d   = st;

    if (sweep) cnt_d = (int'(cnt_eff) == N) ? cnt_eff : cnt_eff + 1'b1;
    else       cnt_d = '0;

    case (st)
      ST_UP_LEFT: begin
        py = (py < STEP) ? 0 : py - STEP;
        px = (px < STEP) ? 0 : px - STEP;
      end
      ST_UP_RIGHT: begin
        py = (py < STEP) ? 0 : py - STEP;
        px = (px + STEP > MAX_X) ? MAX_X : px + STEP;
      end
      ST_DOWN_RIGHT: begin
        py = (py + STEP > MAX_Y) ? MAX_Y : py + STEP;
        px = (px + STEP > MAX_X) ? MAX_X : px + STEP;
      end
      ST_DOWN_LEFT: begin
        py = (py + STEP > MAX_Y) ? MAX_Y : py + STEP;
        px = (px < STEP) ? 0 : px - STEP;
      end
      ST_SHOT: begin
        if (mode_q == MODE_NORMAL) begin
          mode_d   = MODE_FALL;
          flying_d = 1'b1;
        end
      end
      ST_ESCAPE: begin
        if (mode_q == MODE_NORMAL) begin
          mode_d   = MODE_ESCAPE;
          flying_d = 1'b1;
        end
      end
      ST_RESET: begin
        px       = START_X;
        py       = START_Y;
        mode_d   = MODE_NORMAL;
        flying_d = 1'b0;
      end
      ST_CLEAR: begin
        // Animation advances after the last background pixel so the next DRAW sees the new position.
        if (flying_q && (int'(cnt_eff) == N - 1)) begin
          if (mode_q == MODE_FALL) begin
            if (py + FALL_STEP >= MAX_Y) begin
              py       = MAX_Y;
              flying_d = 1'b0;
            end else begin
              py = py + FALL_STEP;
            end
          end else if (mode_q == MODE_ESCAPE) begin
            if (py <= STEP) begin
              py       = 0;
              flying_d = 1'b0;
            end else begin
              py = py - STEP;
            end
          end
        end
      end
      default: ;
    endcase

    pos_x_d = 8'(px);
    pos_y_d = 7'(py);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x_q  <= 8'(START_X);
      pos_y_q  <= 7'(START_Y);
      mode_q   <= MODE_NORMAL;
      flying_q <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= ST_HOLD;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      mode_q   <= mode_d;
      flying_q <= flying_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
    end
  end

endmodule

// File: doc/bird_datapath.md
Name: bird_datapath

Overview:
Datapath responder for the bird control FSM. It consumes the 4-bit bird state code each cycle, owns the bird position and animation mode, and sweeps the sprite rectangle onto the VGA plot interface for clear and draw. It returns done_drawing and flying to the FSM.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
SPRITE_W, 8, sprite width in pixels
SPRITE_H, 8, sprite height in pixels
STEP, 4, pixels moved per move state, also the escape rise per frame
FALL_STEP, 4, pixels fallen per frame after a hit
START_X, 76, x position after reset and after the RESET state
START_Y, 104, y position after reset and after the RESET state
BG_COLOUR, 3'b011, colour used by CLEAR
BIRD_COLOUR, 3'b000, colour used by DRAW in NORMAL and ESCAPE modes
HIT_COLOUR, 3'b100, colour used by DRAW in FALL mode

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
state  in  4  FSM state code
x  out  8  plot x coordinate
y  out  7  plot y coordinate
colour  out  3  plot colour
plot  out  1  pixel write strobe
done_drawing  out  1  current CLEAR or DRAW sweep is complete
flying  out  1  bird is in its fall or escape animation

Behaviour:
- One clock. Reset is synchronous and active-high, and it overrides everything, including a sweep in progress.
- Reset values: pos_x=START_X, pos_y=START_Y, mode=NORMAL, flying=0, cnt=0, prev_state=HOLD. Therefore plot=0 and done_drawing=0.
- State codes:
  - HOLD=0000, CLEAR=0001, UP_LEFT=0010, UP_RIGHT=0011, PREHOLD=0100
  - DRAW=0101, DOWN_RIGHT=0110, DOWN_LEFT=0111
  - SHOT=1000, ESCAPE=1001, RESET=1010
  - Undefined codes behave as HOLD.
- Sweep counter cnt has width clog2(SPRITE_W*SPRITE_H+1).
  - cnt is cleared on any cycle where state != prev_state, or where state is not CLEAR/DRAW.
  - Otherwise cnt increments and saturates at N=SPRITE_W*SPRITE_H.
- Plot outputs are combinational from cnt and position:
  - x = pos_x + cnt % SPRITE_W
  - y = pos_y + cnt / SPRITE_W, row-major order
  - plot = (state is CLEAR or DRAW) && cnt<N
  - colour: BG_COLOUR in CLEAR; in DRAW, HIT_COLOUR if mode=FALL, else BIRD_COLOUR
  - Outside CLEAR/DRAW: plot=0, x=pos_x, y=pos_y.
- Sweep timing: pixel k is plotted on in-state cycle k (k=0..N-1). done_drawing=1 from cycle N and holds while the state is unchanged.
  - A direct CLEAR->DRAW transition restarts the sweep at pixel 0.
- Move states take effect on their clock edge and are applied once per cycle in the state:
  - UP: pos_y = (pos_y<STEP) ? 0 : pos_y-STEP
  - DOWN: pos_y = min(pos_y+STEP, SCREEN_H-SPRITE_H)
  - RIGHT: pos_x = min(pos_x+STEP, SCREEN_W-SPRITE_W)
  - LEFT: pos_x = (pos_x<STEP) ? 0 : pos_x-STEP
  - Clamping: no wrap-around.
- SHOT: if mode=NORMAL, set mode=FALL and flying=1. ESCAPE: if mode=NORMAL, set mode=ESCAPE and flying=1. If mode != NORMAL, both states are no-ops; the first event latched wins.
- Animation step: on the edge where cnt goes N-1 -> N while state=CLEAR, and only when flying=1:
  - FALL: if pos_y+FALL_STEP >= SCREEN_H-SPRITE_H, then pos_y=SCREEN_H-SPRITE_H and flying=0; else pos_y += FALL_STEP.
  - ESCAPE: if pos_y <= STEP, then pos_y=0 and flying=0; else pos_y -= STEP.
  - The step occurs after the last clear pixel, so the following DRAW uses the new position.
- RESET state: pos_x=START_X, pos_y=START_Y, mode=NORMAL, flying=0.
- HOLD and PREHOLD: all registers hold; plot=0, done_drawing=0.

Test Plan:
- Reset then state=CLEAR for 70 cycles -> plot=1 on cycles 0..63; first pixel (76,104), last pixel (83,111), colour 3'b011. done_drawing=1 from cycle 64 with plot=0.
- Reset, then UP_RIGHT for 1 cycle, then DRAW -> first pixel (80,100), colour 3'b000.
- 40 consecutive UP_LEFT cycles from reset -> pos_x=0 and pos_y=0, clamped with no wrap. 40 DOWN_RIGHT cycles -> (152,112).
- SHOT, then repeated CLEAR(65 cycles)/DRAW frames from (76,104):
  - first CLEAR -> pos_y=108
  - second CLEAR -> pos_y=112 and flying=0
  - each DRAW colour 3'b100
- ESCAPE at y=6, then CLEAR for 65 cycles -> y=2, flying=1. Next CLEAR -> y=0, flying=0. SHOT issued mid-escape leaves mode=ESCAPE. RESET -> (76,104), flying=0.
- Assert reset during cycle 30 of a DRAW sweep -> next cycle: plot=0, done_drawing=0, position=(76,104), flying=0. Sweep restarts at pixel 0 on the next DRAW.
